dmem_responder: RTL and testbench

Multi-cycle data-memory responder that serves load/store requests from the pipelined CPU's MEM stage over a request/busy/done handshake. It replaces the single-cycle combinational data memory when the CPU gains stall support. It models a word-addressed SRAM with a configurable access latency and reports misaligned and out-of-range accesses.

---
 rtl/dmem_responder.sv | 124 ++++++++++++
 tb/tb_dmem_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle word-addressed data memory behind a req/busy/done handshake.
// Reports misaligned and out-of-range accesses via err_o alongside done_o.
module dmem_responder #(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int          AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [2:0]  LAT3 = 3'(LATENCY);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_next;
  logic        w_exec;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  // With LATENCY=0 the access happens at the accept edge, so the operands
  // must come straight from the inputs rather than the latches.
  logic        w_op_we;
  logic [31:0] w_op_addr;
  logic [31:0] w_op_wdata;
  logic [29:0] w_idx;
  logic        w_err;

  assign w_op_we    = (r_state == ST_IDLE) ? we_i    : r_we;
  assign w_op_addr  = (r_state == ST_IDLE) ? addr_i  : r_addr;
  assign w_op_wdata = (r_state == ST_IDLE) ? wdata_i : r_wdata;
  assign w_idx      = w_op_addr[31:2];
  assign w_err      = (w_op_addr[1:0] != 2'b00) || (w_idx >= 30'(DEPTH_WORDS));

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_exec       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_i) begin
          w_cnt_next = LAT3;
          if (LATENCY > 0) begin
            w_state_next = ST_WAIT;
          end else begin
            w_state_next = ST_RESP;
            w_exec       = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        w_cnt_next = r_cnt - 3'd1;
        if (r_cnt <= 3'd1) begin
          w_state_next = ST_RESP;
          w_exec       = 1'b1;
        end
      end
      ST_RESP: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (r_state == ST_IDLE && req_i) begin
        r_we    <= we_i;
        r_addr  <= addr_i;
        r_wdata <= wdata_i;
      end
      if (w_exec) begin
        if (w_err) begin
          r_err   <= 1'b1;
          r_rdata <= 32'd0;
        end else begin
          r_err <= 1'b0;
          if (w_op_we) begin
            r_mem[w_idx[AW-1:0]] <= w_op_wdata;
            r_rdata              <= w_op_wdata;
          end else begin
            r_rdata <= r_mem[w_idx[AW-1:0]];
          end
        end
      end
    end
  end

  assign busy_o  = (r_state != ST_IDLE);
  assign done_o  = (r_state == ST_RESP);
  assign rdata_o = r_rdata;
  assign err_o   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for the main
// scenarios and a LATENCY=0 instance for the back-to-back case.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        req = 1'b0, we_s = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic        busy, done, err;
  logic [31:0] rdata;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = 32'd0, wdata0 = 32'd0;
  logic        busy0, done0, err0;
  logic [31:0] rdata0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(128), .LATENCY(2)) u_dut (
    .clk_i(clk), .rst_n(rst_n), .req_i(req), .we_i(we_s), .addr_i(addr),
    .wdata_i(wdata), .busy_o(busy), .done_o(done), .rdata_o(rdata), .err_o(err)
  );

  dmem_responder #(.DEPTH_WORDS(128), .LATENCY(0)) u_dut0 (
    .clk_i(clk), .rst_n(rst_n), .req_i(req0), .we_i(we0), .addr_i(addr0),
    .wdata_i(wdata0), .busy_o(busy0), .done_o(done0), .rdata_o(rdata0), .err_o(err0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on the LATENCY=2 instance, scramble the inputs after
  // accept, and wait (bounded) for done_o. lat counts cycles from accept.
  task automatic do_txn(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd,
                        output logic er, output int lat);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    req = 1'b1; we_s = w; addr = a; wdata = d;
    tick();
    req = 1'b0; we_s = ~w; addr = 32'hFFFF_FFF1; wdata = ~d;
    lat = 1;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    rd = rdata;
    er = err;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          ndone;
    int          acc_idx [$];
    int          seen;

    // Reset held for three cycles
    repeat (3) tick();
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_rdata", rdata,      32'd0);
    chk("rst_err",   32'(err),   32'd0);
    rst_n = 1'b1;

    // First cycle after release: load 0x0
    do_txn("ld0", 1'b0, 32'h0, 32'h0, rd, er, lat);
    chk("ld0_lat",   32'(lat), 32'd3);
    chk("ld0_rdata", rd,       32'h0);
    tick();

    // Store then load
    do_txn("st10", 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    chk("st10_lat",   32'(lat), 32'd3);
    chk("st10_rdata", rd,       32'hDEADBEEF);
    chk("st10_err",   32'(er),  32'd0);
    tick();
    chk("st10_hold",  rdata,    32'hDEADBEEF);
    tick();
    do_txn("ld10", 1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("ld10_lat",   32'(lat), 32'd3);
    chk("ld10_rdata", rd,       32'hDEADBEEF);
    chk("ld10_err",   32'(er),  32'd0);
    tick();

    // Error cases
    do_txn("st13", 1'b1, 32'h13, 32'h12345678, rd, er, lat);
    chk("st13_err",   32'(er), 32'd1);
    chk("st13_rdata", rd,      32'h0);
    tick();
    do_txn("st200", 1'b1, 32'h200, 32'h55555555, rd, er, lat);
    chk("st200_err",  32'(er), 32'd1);
    tick();
    do_txn("st1fc", 1'b1, 32'h1FC, 32'h0BADF00D, rd, er, lat);
    chk("st1fc_err",  32'(er), 32'd0);
    tick();
    do_txn("ld1fc", 1'b0, 32'h1FC, 32'h0, rd, er, lat);
    chk("ld1fc_rdata", rd,     32'h0BADF00D);
    tick();
    do_txn("ld10b", 1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("ld10b_rdata", rd,      32'hDEADBEEF);
    chk("ld10b_err",   32'(er), 32'd0);
    tick();

    // Busy filtering: stores on every cycle 0..9, only 0,4,8 accepted
    ndone = 0;
    for (int c = 0; c < 14; c++) begin
      if (c < 10 && !busy) acc_idx.push_back(c);
      if (done) begin
        chk($sformatf("bf_done_cyc%0d", c), 32'(c), 32'(3 + 4 * ndone));
        chk($sformatf("bf_rdata_cyc%0d", c), rdata, 32'hA000_0000 + 32'(4 * ndone));
        ndone++;
      end
      req   = (c < 10);
      we_s  = 1'b1;
      addr  = 32'h40 + 32'(4 * c);
      wdata = 32'hA000_0000 + 32'(c);
      tick();
    end
    req = 1'b0;
    chk("bf_ndone", 32'(ndone), 32'd3);
    chk("bf_nacc",  32'(acc_idx.size()), 32'd3);
    for (int k = 0; k < acc_idx.size() && k < 3; k++)
      chk($sformatf("bf_acc%0d", k), 32'(acc_idx[k]), 32'(4 * k));
    do_txn("ld44", 1'b0, 32'h44, 32'h0, rd, er, lat);
    chk("ld44_rdata", rd, 32'h0);
    tick();
    do_txn("ld60", 1'b0, 32'h60, 32'h0, rd, er, lat);
    chk("ld60_rdata", rd, 32'hA000_0008);
    tick();

    // Mid-op reset
    req = 1'b1; we_s = 1'b1; addr = 32'h20; wdata = 32'hCAFEF00D;
    tick();
    req = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) seen++;
      tick();
    end
    chk("mr_no_done", 32'(seen), 32'd0);
    do_txn("mr_ld20", 1'b0, 32'h20, 32'h0, rd, er, lat);
    chk("mr_ld20_lat",   32'(lat), 32'd3);
    chk("mr_ld20_rdata", rd,       32'h0);
    tick();

    // LATENCY=0 instance: prime two words
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h8; wdata0 = 32'h11;
    tick();
    req0 = 1'b0;
    chk("l0_st8_done", 32'(done0), 32'd1);
    tick();
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'hC; wdata0 = 32'h22;
    tick();
    req0 = 1'b0;
    chk("l0_stc_done", 32'(done0), 32'd1);
    tick();

    // Back-to-back loads with req0 held high
    chk("l0_n_busy", 32'(busy0), 32'd0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h8;
    tick();
    chk("l0_n1_done",  32'(done0), 32'd1);
    chk("l0_n1_busy",  32'(busy0), 32'd1);
    chk("l0_n1_rdata", rdata0,     32'h11);
    addr0 = 32'hC;
    tick();
    chk("l0_n2_busy",  32'(busy0), 32'd0);
    chk("l0_n2_done",  32'(done0), 32'd0);
    chk("l0_n2_hold",  rdata0,     32'h11);
    tick();
    req0 = 1'b0;
    chk("l0_n3_done",  32'(done0), 32'd1);
    chk("l0_n3_rdata", rdata0,     32'h22);
    chk("l0_n3_err",   32'(err0),  32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
